// File: rtl/fb_sched_pkg.sv
// Shared types for the triple-buffer frame scheduler:
// FSM encodings, buffer index type, grant-side codes.
package fb_sched_pkg;

  localparam int NUM_BUF = 3;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0] idx_t;

  localparam logic GNT_R = 1'b0;
  localparam logic GNT_W = 1'b1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACK_WR  = 3'd1;
  localparam logic [2:0] ST_HOLD_WR = 3'd2;
  localparam logic [2:0] ST_ACK_RD  = 3'd3;
  localparam logic [2:0] ST_HOLD_RD = 3'd4;

  function automatic idx_t idx_inc(input idx_t i);
    return (i == idx_t'(NUM_BUF - 1)) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// Request/ack bundle between the scheduler and its requesters.
// master = writer/display side, slave = scheduler.
interface frame_buffer_scheduler_if #(
  parameter int ADDR_WIDTH = 25,
  parameter int CNT_WIDTH  = 16
);

  logic                  write_req;
  logic                  write_req_ack;
  logic                  write_done;
  logic [ADDR_WIDTH-1:0] write_base;
  logic                  read_req;
  logic                  read_req_ack;
  logic [ADDR_WIDTH-1:0] read_base;
  logic                  frame_new;
  logic [CNT_WIDTH-1:0]  drop_cnt;

  modport master (
    output write_req,
    output write_done,
    output read_req,
    input  write_req_ack,
    input  write_base,
    input  read_req_ack,
    input  read_base,
    input  frame_new,
    input  drop_cnt
  );

  modport slave (
    input  write_req,
    input  write_done,
    input  read_req,
    output write_req_ack,
    output write_base,
    output read_req_ack,
    output read_base,
    output frame_new,
    output drop_cnt
  );

endinterface

// File: rtl/fb_index_pick.sv
// Picks the next write buffer: never the displayed one, and
// never an unread completed frame unless it is displayed.
import fb_sched_pkg::*;

module fb_index_pick (
  input  idx_t rd_idx,
  input  idx_t latest_idx,
  input  logic latest_valid,
  output idx_t wr_idx
);

  idx_t c1;
  idx_t c2;
  logic blk;

  always_comb begin
    c1     = idx_inc(rd_idx);
    c2     = idx_inc(c1);
    blk    = latest_valid &&
             (latest_idx != rd_idx) &&
             (latest_idx == c1);
    wr_idx = blk ? c2 : c1;
  end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler: grants read/write buffers over
// req/ack, hands out base addresses, counts dropped frames.
// Ports: clk, rst (async high), bus (slave modport).
import fb_sched_pkg::*;

module frame_buffer_scheduler #(
  parameter int ADDR_WIDTH = 25,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE =
    ADDR_WIDTH'(25'h0100000),
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  frame_buffer_scheduler_if.slave bus
);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  function automatic addr_t base_of(input idx_t i);
    addr_t off;
    off = '0;
    if (i[0]) off = off + FRAME_STRIDE;
    if (i[1]) off = off + (FRAME_STRIDE << 1);
    return BASE_ADDR + off;
  endfunction

  logic [2:0] state_q, state_d;
  idx_t  rd_idx_q, rd_idx_d;
  idx_t  wr_idx_q, wr_idx_d;
  idx_t  latest_idx_q, latest_idx_d;
  logic  latest_valid_q, latest_valid_d;
  logic  wr_active_q, wr_active_d;
  logic  last_grant_q, last_grant_d;
  logic  wr_ack_q, wr_ack_d;
  logic  rd_ack_q, rd_ack_d;
  logic  frame_new_q, frame_new_d;
  cnt_t  drop_cnt_q, drop_cnt_d;
  addr_t read_base_q, read_base_d;
  addr_t write_base_q, write_base_d;

  logic  wr_gnt;
  logic  rd_gnt;
  logic  done_hit;
  idx_t  pick_idx;

  // Arbitration and handshake sequencing
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_gnt       = 1'b0;
    rd_gnt       = 1'b0;
    wr_ack_d     = 1'b0;
    rd_ack_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // On collision the side not granted last time wins
        unique case (1'b1)
          bus.write_req &&
            (!bus.read_req || last_grant_q == GNT_R):
            wr_gnt = 1'b1;
          bus.read_req &&
            (!bus.write_req || last_grant_q == GNT_W):
            rd_gnt = 1'b1;
          default: ;
        endcase
        if (wr_gnt) begin
          state_d      = ST_ACK_WR;
          wr_ack_d     = 1'b1;
          last_grant_d = GNT_W;
        end
        if (rd_gnt) begin
          state_d      = ST_ACK_RD;
          rd_ack_d     = 1'b1;
          last_grant_d = GNT_R;
        end
      end
      ST_ACK_WR:  state_d = ST_HOLD_WR;
      ST_HOLD_WR: if (!bus.write_req) state_d = ST_IDLE;
      ST_ACK_RD:  state_d = ST_HOLD_RD;
      ST_HOLD_RD: if (!bus.read_req) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Read grant first, then completion: a frame finished on
  // the same edge as a read grant is served on the next read.
  always_comb begin
    rd_idx_d       = rd_idx_q;
    frame_new_d    = frame_new_q;
    read_base_d    = read_base_q;
    latest_idx_d   = latest_idx_q;
    latest_valid_d = latest_valid_q;
    drop_cnt_d     = drop_cnt_q;
    done_hit       = bus.write_done && wr_active_q;
    if (rd_gnt) begin
      frame_new_d = latest_valid_q;
      if (latest_valid_q) begin
        rd_idx_d       = latest_idx_q;
        latest_valid_d = 1'b0;
      end
      read_base_d = base_of(rd_idx_d);
    end
    if (done_hit) begin
      if (latest_valid_d && drop_cnt_q != '1)
        drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      latest_idx_d   = wr_idx_q;
      latest_valid_d = 1'b1;
    end
  end

  // Pick sees post-completion latest so a frame finished on
  // the grant edge is protected too.
  fb_index_pick u_pick (
    .rd_idx       (rd_idx_q),
    .latest_idx   (latest_idx_d),
    .latest_valid (latest_valid_d),
    .wr_idx       (pick_idx)
  );

  always_comb begin
    wr_idx_d     = wr_idx_q;
    write_base_d = write_base_q;
    wr_active_d  = wr_active_q;
    if (done_hit) wr_active_d = 1'b0;
    if (wr_gnt) begin
      wr_idx_d     = pick_idx;
      write_base_d = base_of(pick_idx);
      wr_active_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rd_idx_q       <= idx_t'(0);
      wr_idx_q       <= idx_t'(1);
      latest_idx_q   <= idx_t'(0);
      latest_valid_q <= 1'b0;
      wr_active_q    <= 1'b0;
      last_grant_q   <= GNT_R;
      wr_ack_q       <= 1'b0;
      rd_ack_q       <= 1'b0;
      frame_new_q    <= 1'b0;
      drop_cnt_q     <= '0;
      read_base_q    <= BASE_ADDR;
      write_base_q   <= BASE_ADDR + FRAME_STRIDE;
    end else begin
      state_q        <= state_d;
      rd_idx_q       <= rd_idx_d;
      wr_idx_q       <= wr_idx_d;
      latest_idx_q   <= latest_idx_d;
      latest_valid_q <= latest_valid_d;
      wr_active_q    <= wr_active_d;
      last_grant_q   <= last_grant_d;
      wr_ack_q       <= wr_ack_d;
      rd_ack_q       <= rd_ack_d;
      frame_new_q    <= frame_new_d;
      drop_cnt_q     <= drop_cnt_d;
      read_base_q    <= read_base_d;
      write_base_q   <= write_base_d;
    end
  end

  assign bus.write_req_ack = wr_ack_q;
  assign bus.read_req_ack  = rd_ack_q;
  assign bus.write_base    = write_base_q;
  assign bus.read_base     = read_base_q;
  assign bus.frame_new     = frame_new_q;
  assign bus.drop_cnt      = drop_cnt_q;

endmodule
